// File: rtl/mm_req_arbiter.sv
// rtl/mm_req_arbiter.sv - shares the main-memory port between I$ and D$ misses
// D$ has priority, bounded by an I$ anti-starvation run limit; one pending miss per cache.
package mm_req_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic [LINE_W-1:0] data;
  } memory_request_t;
endpackage

module mm_req_arbiter
  import mm_req_pkg::*;
#(
  parameter int REQ_LAT   = 4,
  parameter int MAX_D_RUN = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              icache_req_valid,
  input  memory_request_t   icache_req_info,
  input  logic              dcache_req_valid,
  input  memory_request_t   dcache_req_info,
  output logic              mem_req_valid,
  output memory_request_t   mem_req_info,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_bus_error,
  output logic              rsp_valid_miss,
  output logic              rsp_cache_id,
  output logic [LINE_W-1:0] rsp_data_miss,
  output logic              rsp_bus_error,
  output logic              req_overflow
);
  localparam int LAT_W = (REQ_LAT > 1) ? $clog2(REQ_LAT) : 1;
  localparam int RUN_W = $clog2(MAX_D_RUN + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEM, S_RESP} state_t;

  state_t          state_q, state_d;
  logic            sel_q;
  logic [1:0]      pend_q;
  memory_request_t buf_q [2];
  memory_request_t req_info [2];
  logic [LAT_W-1:0] lat_cnt_q;
  logic [RUN_W-1:0] d_run_q;
  logic [1:0]      req_valid, resp_slot, accept, drop;
  logic            grant, grant_d;

  assign req_valid   = {dcache_req_valid, icache_req_valid};
  assign req_info[0] = icache_req_info;
  assign req_info[1] = dcache_req_info;

  // The source being answered may refill its buffer in its own RESP cycle.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      resp_slot[s] = (state_q == S_RESP) && (sel_q == 1'(s));
      accept[s]    = req_valid[s] && (!pend_q[s] || resp_slot[s]);
      drop[s]      = req_valid[s] && !accept[s];
    end
  end

  always_comb begin
    grant   = (state_q == S_IDLE) && (pend_q != 2'b00);
    grant_d = pend_q[1] && !(pend_q[0] && (d_run_q == RUN_W'(MAX_D_RUN)));
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      lat_cnt_q <= '0;
      d_run_q   <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= (state_q == S_WAIT) ? lat_cnt_q + 1'b1 : '0;
      if (grant) begin
        sel_q <= grant_d;
        if (!grant_d || !pend_q[0])
          d_run_q <= '0;
        else if (d_run_q != RUN_W'(MAX_D_RUN))
          d_run_q <= d_run_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant) state_d = (REQ_LAT == 0) ? S_MEM : S_WAIT;
      S_WAIT:  if (lat_cnt_q == LAT_W'(REQ_LAT - 1)) state_d = S_MEM;
      S_MEM:   if (mem_rsp_valid) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid = (state_q == S_MEM);
    mem_req_info  = mem_req_valid ? buf_q[sel_q] : '0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_q   <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (accept[s]) begin
          buf_q[s]  <= req_info[s];
          pend_q[s] <= 1'b1;
        end else if (resp_slot[s]) begin
          pend_q[s] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rsp_valid_miss <= 1'b0;
      rsp_cache_id   <= 1'b0;
      rsp_data_miss  <= '0;
      rsp_bus_error  <= 1'b0;
      req_overflow   <= 1'b0;
    end else begin
      rsp_valid_miss <= (state_q == S_RESP);
      req_overflow   <= |drop;
      if ((state_q == S_MEM) && mem_rsp_valid) begin
        rsp_data_miss <= mem_rsp_data;
        rsp_bus_error <= mem_rsp_bus_error;
      end
      if (state_q == S_RESP)
        rsp_cache_id <= sel_q;
    end
  end
endmodule

// File: tb/tb_mm_req_arbiter.sv
// tb/tb_mm_req_arbiter.sv - directed and randomized checks of mm_req_arbiter
// Expected behaviour comes from a transaction-timing model of pending slots, grants and memory latency.
module tb_mm_req_arbiter;
  import mm_req_pkg::*;

  localparam int REQ_LAT   = 4;
  localparam int MAX_D_RUN = 4;
  localparam int DEPTH     = 256;

  logic            clk = 1'b0;
  logic            reset_ni = 1'b0;
  logic            icache_req_valid, dcache_req_valid;
  memory_request_t icache_req_info, dcache_req_info;
  logic            mem_req_valid;
  memory_request_t mem_req_info;
  logic            mem_rsp_valid, mem_rsp_bus_error;
  logic [127:0]    mem_rsp_data;
  logic            rsp_valid_miss, rsp_cache_id, rsp_bus_error, req_overflow;
  logic [127:0]    rsp_data_miss;
  logic            z_mem_req_valid, z_rsp_valid, z_rsp_id, z_rsp_err, z_req_overflow;
  memory_request_t z_mem_req_info;
  logic [127:0]    z_rsp_data;

  always #5 clk = ~clk;

  mm_req_arbiter #(.REQ_LAT(REQ_LAT), .MAX_D_RUN(MAX_D_RUN)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .icache_req_valid(icache_req_valid), .icache_req_info(icache_req_info),
    .dcache_req_valid(dcache_req_valid), .dcache_req_info(dcache_req_info),
    .mem_req_valid(mem_req_valid), .mem_req_info(mem_req_info),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_bus_error(mem_rsp_bus_error),
    .rsp_valid_miss(rsp_valid_miss), .rsp_cache_id(rsp_cache_id), .rsp_data_miss(rsp_data_miss),
    .rsp_bus_error(rsp_bus_error), .req_overflow(req_overflow)
  );

  mm_req_arbiter #(.REQ_LAT(0), .MAX_D_RUN(MAX_D_RUN)) dut0 (
    .clk_i(clk), .reset_ni(reset_ni),
    .icache_req_valid(icache_req_valid), .icache_req_info(icache_req_info),
    .dcache_req_valid(dcache_req_valid), .dcache_req_info(dcache_req_info),
    .mem_req_valid(z_mem_req_valid), .mem_req_info(z_mem_req_info),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_bus_error(mem_rsp_bus_error),
    .rsp_valid_miss(z_rsp_valid), .rsp_cache_id(z_rsp_id), .rsp_data_miss(z_rsp_data),
    .rsp_bus_error(z_rsp_err), .req_overflow(z_req_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a + 32'h1234_5678, a[15:0], a[15:0]};
  endfunction

  function automatic memory_request_t mk(input logic [31:0] a, input bit st);
    memory_request_t r;
    r.addr     = a;
    r.is_store = st;
    r.data     = {$urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  // Model state: one slot per cache plus the transaction currently owning memory.
  memory_request_t m_info [2];
  bit           m_pend [2];
  bit           m_busy, m_src, m_responded, m_rsp_id, m_rsp_err, stray_en;
  int           m_mem_start, m_lat, m_resp_cyc, m_rsp_at, m_ovf_at, m_d_run, m_fixed_lat;
  logic [127:0] m_rsp_data;
  int           cyc = 0;

  int           first_mem, last_mem, first_rsp, id_cnt, ovf_cnt;
  logic [31:0]  id_bits, err_bits;
  logic [127:0] last_data;
  int           z_first_mem, z_rsp_cyc, z_ovf_cnt;
  memory_request_t z_info;
  logic         z_id, z_err;
  logic [127:0] z_data;

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0; m_busy = 0; m_src = 0; m_responded = 0;
    m_mem_start = 0; m_lat = 1; m_resp_cyc = -1; m_rsp_at = -1; m_ovf_at = -1; m_d_run = 0;
    m_rsp_id = 0; m_rsp_err = 0; m_rsp_data = '0;
  endtask

  task automatic clear_obs();
    first_mem = -1; last_mem = -1; first_rsp = -1; id_cnt = 0; ovf_cnt = 0;
    id_bits = '0; err_bits = '0; last_data = '0;
    z_first_mem = -1; z_rsp_cyc = -1; z_ovf_cnt = 0; z_info = '0; z_id = 0; z_err = 0; z_data = '0;
  endtask

  function automatic bit model_idle();
    return !m_busy && !m_pend[0] && !m_pend[1] && cyc > m_rsp_at && cyc > m_ovf_at;
  endfunction

  task automatic step(input bit iv, input memory_request_t ii, input bit dv, input memory_request_t di);
    bit active, was_resp, mr, re, drop, to_d;
    logic [127:0] rd;
    active   = m_busy && cyc >= m_mem_start && !m_responded;
    was_resp = m_busy && m_responded && cyc == m_resp_cyc;
    mr = 1'b0;
    rd = {$urandom, $urandom, $urandom, $urandom};
    re = 1'($urandom_range(0, 1));
    if (active) begin
      mr = (cyc >= m_mem_start + m_lat - 1);
      rd = mem_line(m_info[m_src].addr);
      re = (m_info[m_src].addr >= DEPTH);
    end else if (stray_en) begin
      mr = ($urandom_range(0, 5) == 0);
    end
    @(posedge clk);
    #1;
    icache_req_valid = iv; icache_req_info = ii;
    dcache_req_valid = dv; dcache_req_info = di;
    mem_rsp_valid = mr; mem_rsp_data = rd; mem_rsp_bus_error = re;
    @(negedge clk);

    check_eq("mem_req_valid", mem_req_valid, active);
    if (active) check_eq("mem_req_info", mem_req_info, m_info[m_src]);
    check_eq("rsp_valid_miss", rsp_valid_miss, cyc == m_rsp_at);
    if (cyc == m_rsp_at) begin
      check_eq("rsp_cache_id", rsp_cache_id, m_rsp_id);
      check_eq("rsp_data_miss", rsp_data_miss, m_rsp_data);
      check_eq("rsp_bus_error", rsp_bus_error, m_rsp_err);
    end
    check_eq("req_overflow", req_overflow, cyc == m_ovf_at);

    if (mem_req_valid) begin
      if (first_mem < 0) first_mem = cyc;
      last_mem = cyc;
    end
    if (rsp_valid_miss) begin
      if (first_rsp < 0) first_rsp = cyc;
      id_bits  = {id_bits[30:0], rsp_cache_id};
      err_bits = {err_bits[30:0], rsp_bus_error};
      id_cnt++;
      last_data = rsp_data_miss;
    end
    if (req_overflow) ovf_cnt++;
    if (z_mem_req_valid && z_first_mem < 0) begin
      z_first_mem = cyc;
      z_info = z_mem_req_info;
    end
    if (z_rsp_valid && z_rsp_cyc < 0) begin
      z_rsp_cyc = cyc; z_id = z_rsp_id; z_err = z_rsp_err; z_data = z_rsp_data;
    end
    if (z_req_overflow) z_ovf_cnt++;

    if (!m_busy) begin
      if (m_pend[0] || m_pend[1]) begin
        to_d = m_pend[1] && !(m_pend[0] && m_d_run == MAX_D_RUN);
        if (to_d && m_pend[0]) m_d_run = (m_d_run < MAX_D_RUN) ? m_d_run + 1 : MAX_D_RUN;
        else m_d_run = 0;
        m_busy = 1; m_src = to_d; m_responded = 0;
        m_mem_start = cyc + REQ_LAT + 1;
        m_lat = (m_fixed_lat > 0) ? m_fixed_lat : int'($urandom_range(1, 5));
      end
    end else if (active && mr) begin
      m_responded = 1; m_resp_cyc = cyc + 1; m_rsp_at = cyc + 2;
      m_rsp_id = m_src; m_rsp_data = rd; m_rsp_err = re;
    end else if (was_resp) begin
      m_busy = 0;
      m_pend[m_src] = 0;
    end
    drop = 0;
    if (iv) begin
      if (!m_pend[0]) begin m_info[0] = ii; m_pend[0] = 1; end
      else drop = 1;
    end
    if (dv) begin
      if (!m_pend[1]) begin m_info[1] = di; m_pend[1] = 1; end
      else drop = 1;
    end
    if (drop) m_ovf_at = cyc + 1;
    cyc++;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (!model_idle() && n < max) begin
      step(0, '0, 0, '0);
      n++;
    end
    check_eq("idle_timeout", model_idle(), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int t0, n, re_cnt;
    bit dre;
    memory_request_t r1;
    icache_req_valid = 0; dcache_req_valid = 0; icache_req_info = '0; dcache_req_info = '0;
    mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_bus_error = 0;
    model_reset();
    clear_obs();
    m_fixed_lat = 3;
    stray_en = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_mem_req_valid", mem_req_valid, 1'b0);
    check_eq("reset_mem_req_info", mem_req_info, '0);
    check_eq("reset_rsp_valid", rsp_valid_miss, 1'b0);
    check_eq("reset_rsp_id", rsp_cache_id, 1'b0);
    check_eq("reset_rsp_data", rsp_data_miss, '0);
    check_eq("reset_rsp_err", rsp_bus_error, 1'b0);
    check_eq("reset_overflow", req_overflow, 1'b0);
    reset_ni = 1;

    // Lone I$ miss, memory latency 3
    clear_obs();
    t0 = cyc;
    r1 = mk(32'h20, 0);
    step(1, r1, 0, '0);
    run_idle(100);
    check_eq("t1_mem_first", first_mem - t0, 6);
    check_eq("t1_mem_last", last_mem - t0, 8);
    check_eq("t1_rsp_cycle", first_rsp - t0, 10);
    check_eq("t1_rsp_count", id_cnt, 1);
    check_eq("t1_rsp_id", id_bits, 0);
    check_eq("t1_rsp_data", last_data, mem_line(32'h20));
    check_eq("t1_lat0_mem_first", z_first_mem - t0, 2);
    check_eq("t1_lat0_mem_info", z_info, r1);
    check_eq("t1_lat0_rsp_cycle", z_rsp_cyc - t0, 10);
    check_eq("t1_lat0_rsp_id", z_id, 1'b0);
    check_eq("t1_lat0_rsp_data", z_data, mem_line(32'h20));
    check_eq("t1_lat0_rsp_err", z_err, 1'b0);
    check_eq("t1_lat0_overflow", z_ovf_cnt, 0);

    // Simultaneous I$ and D$: D$ first
    clear_obs();
    step(1, mk(32'h30, 0), 1, mk(32'h34, 1));
    run_idle(100);
    check_eq("t2_rsp_count", id_cnt, 2);
    check_eq("t2_rsp_order", id_bits, 32'b10);

    // D$ refills in each of its RESP cycles while I$ waits
    clear_obs();
    re_cnt = 0;
    step(1, mk(32'h40, 0), 1, mk(32'h44, 0));
    n = 0;
    while (!model_idle() && n < 400) begin
      dre = m_busy && m_responded && cyc == m_resp_cyc && m_src && re_cnt < 5;
      if (dre) re_cnt++;
      step(0, '0, dre, mk(32'h48 + 32'(re_cnt), 0));
      n++;
    end
    check_eq("t3_idle_timeout", model_idle(), 1'b1);
    check_eq("t3_rsp_count", id_cnt, 7);
    check_eq("t3_rsp_order", id_bits, 32'b1111011);

    // D$ pulses again while its first miss is pending
    clear_obs();
    r1 = mk(32'h60, 0);
    step(0, '0, 1, r1);
    step(0, '0, 0, '0);
    step(0, '0, 1, mk(32'h64, 0));
    run_idle(100);
    check_eq("t4_overflow_count", ovf_cnt, 1);
    check_eq("t4_rsp_count", id_cnt, 1);
    check_eq("t4_rsp_data", last_data, mem_line(32'h60));

    // Bus error then a normal request
    clear_obs();
    step(0, '0, 1, mk(32'h1000, 0));
    run_idle(100);
    step(0, '0, 1, mk(32'h44, 0));
    run_idle(100);
    check_eq("t5_rsp_count", id_cnt, 2);
    check_eq("t5_rsp_ids", id_bits, 32'b11);
    check_eq("t5_rsp_errs", err_bits, 32'b10);

    // Asynchronous reset while the request is on the memory port
    step(0, '0, 1, mk(32'h80, 0));
    n = 0;
    while (!(m_busy && cyc > m_mem_start) && n < 50) begin
      step(0, '0, 0, '0);
      n++;
    end
    check_eq("t6_in_mem", mem_req_valid, 1'b1);
    #2 reset_ni = 0;
    #1;
    check_eq("t6_mem_req_valid", mem_req_valid, 1'b0);
    check_eq("t6_mem_req_info", mem_req_info, '0);
    check_eq("t6_rsp_valid", rsp_valid_miss, 1'b0);
    check_eq("t6_rsp_id", rsp_cache_id, 1'b0);
    check_eq("t6_rsp_data", rsp_data_miss, '0);
    check_eq("t6_rsp_err", rsp_bus_error, 1'b0);
    check_eq("t6_overflow", req_overflow, 1'b0);
    model_reset();
    icache_req_valid = 0; dcache_req_valid = 0; mem_rsp_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ni = 1;
    clear_obs();
    repeat (12) step(0, '0, 0, '0);
    check_eq("t6_no_rsp", id_cnt, 0);
    check_eq("t6_no_mem", first_mem, -1);
    step(1, mk(32'h90, 0), 0, '0);
    run_idle(100);
    check_eq("t6_after_rsp_count", id_cnt, 1);
    check_eq("t6_after_rsp_id", id_bits, 0);

    // Random traffic with random latency and stray memory responses
    m_fixed_lat = 0;
    stray_en = 1;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 5) == 0, mk(32'($urandom_range(0, 299)), 1'($urandom_range(0, 1))),
           $urandom_range(0, 5) == 0, mk(32'($urandom_range(0, 299)), 1'($urandom_range(0, 1))));
    end
    run_idle(200);
    stray_en = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
